// File: rtl/response_collector_pkg.sv
// Shared definitions for the sensor response collector: FSM encoding,
// frame layout and the address-byte format shared with the request dispatcher.
package response_collector_pkg;

  // Sensor address width and the zero padding that fills the address byte
  localparam int unsigned ADDR_W     = 5;
  localparam int unsigned ADDR_PAD_W = 3;
  localparam logic [ADDR_PAD_W-1:0] ADDR_PAD = 3'b000;

  // Frame layout: address byte, then response code, then measurement
  localparam int unsigned FRAME_LEN  = 3;
  localparam int unsigned BYTE_IDX_W = 2;
  localparam logic [BYTE_IDX_W-1:0] BYTE_ADDR = 2'd0;
  localparam logic [BYTE_IDX_W-1:0] BYTE_CODE = 2'd1;
  localparam logic [BYTE_IDX_W-1:0] BYTE_DATA = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_CAPTURE   = 2'd1,
    ST_SEND      = 2'd2,
    ST_WAIT_DONE = 2'd3
  } state_e;

endpackage

// File: rtl/response_collector_if.sv
// Bundle of the sensor-response and uart_tx handshake signals.
//   resp_valid/resp_code/resp_data : sensor array -> collector
//   resp_ack                       : collector -> sensor array
//   tx_data/tx_start               : collector -> uart_tx
//   tx_done                        : uart_tx -> collector
//   busy                           : collector status
// slave = collector side, master = sensor array / uart side.
interface response_collector_if #(
  parameter int unsigned N_SENSORS = 8,
  parameter int unsigned DATA_W    = 8
) ();

  logic [N_SENSORS-1:0]        resp_valid;
  logic [N_SENSORS*DATA_W-1:0] resp_code;
  logic [N_SENSORS*DATA_W-1:0] resp_data;
  logic [N_SENSORS-1:0]        resp_ack;
  logic [DATA_W-1:0]           tx_data;
  logic                        tx_start;
  logic                        tx_done;
  logic                        busy;

  modport slave (
    input  resp_valid, resp_code, resp_data, tx_done,
    output resp_ack, tx_data, tx_start, busy
  );

  modport master (
    output resp_valid, resp_code, resp_data, tx_done,
    input  resp_ack, tx_data, tx_start, busy
  );

endinterface

// File: rtl/response_collector_rr_arbiter.sv
// Combinational round-robin arbiter: picks the first set request at or
// above rr_ptr_i, wrapping at N_SENSORS-1 -> 0. The pointer lives in the parent.
//   req_i     : pending request vector
//   rr_ptr_i  : highest-priority index for this decision
//   grant_o   : granted index (valid when any_req_o)
//   any_req_o : at least one request pending
module response_collector_rr_arbiter
  import response_collector_pkg::*;
#(
  parameter int unsigned N_SENSORS = 8
) (
  input  logic [N_SENSORS-1:0] req_i,
  input  logic [ADDR_W-1:0]    rr_ptr_i,
  output logic [ADDR_W-1:0]    grant_o,
  output logic                 any_req_o
);

  localparam int unsigned IDX_W = (N_SENSORS > 1) ? $clog2(N_SENSORS) : 1;
  // ptr + offset stays below 2*N_SENSORS, so one extra bit suffices
  localparam int unsigned SUM_W = ADDR_W + 1;

  logic [SUM_W-1:0] cand;
  logic [IDX_W-1:0] cand_idx;

  // Scan offsets from the far end so the smallest offset wins last
  always_comb begin
    grant_o   = '0;
    any_req_o = 1'b0;
    cand      = '0;
    cand_idx  = '0;
    for (int i = int'(N_SENSORS) - 1; i >= 0; i--) begin
      cand = SUM_W'(rr_ptr_i) + SUM_W'(i);
      if (cand >= SUM_W'(N_SENSORS)) begin
        cand = cand - SUM_W'(N_SENSORS);
      end
      cand_idx = IDX_W'(cand);
      if (req_i[cand_idx]) begin
        grant_o   = ADDR_W'(cand);
        any_req_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/response_collector.sv
// Collects sensor responses round-robin and serialises each into a 3-byte
// frame {addr, code, data} for uart_tx, one frame in flight at a time.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : slave side of response_collector_if
//                (resp_valid/code/data in, resp_ack out,
//                 tx_data/tx_start out, tx_done in, busy out)
module response_collector
  import response_collector_pkg::*;
#(
  parameter int unsigned N_SENSORS = 8,
  parameter int unsigned DATA_W    = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  response_collector_if.slave  bus
);

  localparam int unsigned IDX_W = (N_SENSORS > 1) ? $clog2(N_SENSORS) : 1;

  state_e                  state_q, state_d;
  logic [ADDR_W-1:0]       rr_ptr_q, rr_ptr_d;
  logic [BYTE_IDX_W-1:0]   byte_idx_q, byte_idx_d;
  logic [ADDR_W-1:0]       addr_q, addr_d;
  logic [DATA_W-1:0]       code_q, code_d;
  logic [DATA_W-1:0]       data_q, data_d;
  logic [N_SENSORS-1:0]    resp_ack_q, resp_ack_d;
  logic                    tx_start_q, tx_start_d;
  logic [DATA_W-1:0]       tx_data_q, tx_data_d;
  logic                    busy_q, busy_d;

  logic [ADDR_W-1:0]       grant;
  logic                    any_req;
  logic [IDX_W-1:0]        grant_idx;

  logic [DATA_W-1:0]       code_arr [N_SENSORS];
  logic [DATA_W-1:0]       data_arr [N_SENSORS];

  // Unpack the flattened per-sensor buses
  for (genvar g = 0; g < N_SENSORS; g++) begin : g_unpack
    assign code_arr[g] = bus.resp_code[g*DATA_W +: DATA_W];
    assign data_arr[g] = bus.resp_data[g*DATA_W +: DATA_W];
  end

  response_collector_rr_arbiter #(
    .N_SENSORS (N_SENSORS)
  ) u_rr_arbiter (
    .req_i     (bus.resp_valid),
    .rr_ptr_i  (rr_ptr_q),
    .grant_o   (grant),
    .any_req_o (any_req)
  );

  assign grant_idx = IDX_W'(grant);

  // Frame byte selector over the frozen capture registers
  function automatic logic [DATA_W-1:0] frame_byte(
    input logic [BYTE_IDX_W-1:0] idx,
    input logic [ADDR_W-1:0]     addr,
    input logic [DATA_W-1:0]     code,
    input logic [DATA_W-1:0]     data
  );
    logic [DATA_W-1:0] b;
    case (idx)
      BYTE_ADDR: b = DATA_W'({ADDR_PAD, addr});
      BYTE_CODE: b = code;
      default:   b = data;
    endcase
    return b;
  endfunction

  // Next-state and next-output logic; outputs are computed for the state
  // being entered so that they appear registered in that state.
  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    byte_idx_d = byte_idx_q;
    addr_d     = addr_q;
    code_d     = code_q;
    data_d     = data_q;
    resp_ack_d = '0;
    tx_start_d = 1'b0;
    tx_data_d  = tx_data_q;

    case (state_q)
      ST_IDLE: begin
        if (any_req) begin
          addr_d     = grant;
          code_d     = code_arr[grant_idx];
          data_d     = data_arr[grant_idx];
          resp_ack_d = N_SENSORS'(1) << grant;
          state_d    = ST_CAPTURE;
        end
      end
      ST_CAPTURE: begin
        byte_idx_d = BYTE_ADDR;
        tx_start_d = 1'b1;
        tx_data_d  = frame_byte(BYTE_ADDR, addr_q, code_q, data_q);
        state_d    = ST_SEND;
      end
      ST_SEND: begin
        // tx_done here (even coincident with tx_start) is not the end of this byte
        state_d = ST_WAIT_DONE;
      end
      ST_WAIT_DONE: begin
        if (bus.tx_done) begin
          if (byte_idx_q == BYTE_IDX_W'(FRAME_LEN - 1)) begin
            rr_ptr_d = (addr_q == ADDR_W'(N_SENSORS - 1)) ? '0 : addr_q + ADDR_W'(1);
            state_d  = ST_IDLE;
          end else begin
            byte_idx_d = byte_idx_q + BYTE_IDX_W'(1);
            tx_start_d = 1'b1;
            tx_data_d  = frame_byte(byte_idx_q + BYTE_IDX_W'(1), addr_q, code_q, data_q);
            state_d    = ST_SEND;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      rr_ptr_q   <= '0;
      byte_idx_q <= '0;
      addr_q     <= '0;
      code_q     <= '0;
      data_q     <= '0;
      resp_ack_q <= '0;
      tx_start_q <= 1'b0;
      tx_data_q  <= '0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      byte_idx_q <= byte_idx_d;
      addr_q     <= addr_d;
      code_q     <= code_d;
      data_q     <= data_d;
      resp_ack_q <= resp_ack_d;
      tx_start_q <= tx_start_d;
      tx_data_q  <= tx_data_d;
      busy_q     <= busy_d;
    end
  end

  assign bus.resp_ack = resp_ack_q;
  assign bus.tx_start = tx_start_q;
  assign bus.tx_data  = tx_data_q;
  assign bus.busy     = busy_q;

endmodule

// File: tb/tb_response_collector.sv
// Directed bench for response_collector with a scoreboard of expected acks
// and frame bytes, plus a uart_tx model answering tx_done 10 cycles after tx_start.
module tb_response_collector;

  localparam int unsigned N = 8;
  localparam int unsigned W = 8;

  logic clk;
  logic rst_n;

  response_collector_if #(.N_SENSORS(N), .DATA_W(W)) bus_if ();

  response_collector #(.N_SENSORS(N), .DATA_W(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          checks;
  int          errors;
  int unsigned cyc;
  int unsigned uart_cnt;
  int unsigned n_starts;
  int unsigned last_start_cyc;
  int unsigned byte_pos;
  bit          spur_idle;
  bit          spur_start;
  logic [7:0]  last_byte;
  logic [7:0]  exp_ack_q  [$];
  logic [7:0]  exp_byte_q [$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_sensor(input int s, input logic [7:0] c, input logic [7:0] d);
    bus_if.resp_code[s*W +: W] = c;
    bus_if.resp_data[s*W +: W] = d;
  endtask

  task automatic push_frame(input int s, input logic [7:0] c, input logic [7:0] d);
    logic [7:0] a;
    a = 8'd1 << s;
    exp_ack_q.push_back(a);
    exp_byte_q.push_back(8'(s));
    exp_byte_q.push_back(c);
    exp_byte_q.push_back(d);
  endtask

  // One clock: sample at negedge, score outputs, then drive sensors/uart
  task automatic step();
    logic [7:0] e;
    logic       done_nxt;
    @(negedge clk);
    cyc++;
    if (bus_if.resp_ack !== '0) begin
      if (exp_ack_q.size() == 0) begin
        check("unexpected_ack", 32'(bus_if.resp_ack), 32'h0);
      end else begin
        e = exp_ack_q.pop_front();
        check("ack", 32'(bus_if.resp_ack), 32'(e));
      end
      bus_if.resp_valid = bus_if.resp_valid & ~bus_if.resp_ack;
    end
    if (bus_if.tx_start !== 1'b0) begin
      n_starts++;
      if (byte_pos != 0) check("byte_gap", 32'(cyc - last_start_cyc), 32'd11);
      if (exp_byte_q.size() == 0) begin
        check("unexpected_start", 32'(bus_if.tx_start), 32'h0);
      end else begin
        e = exp_byte_q.pop_front();
        check("tx_byte", 32'(bus_if.tx_data), 32'(e));
      end
      last_byte      = bus_if.tx_data;
      last_start_cyc = cyc;
      byte_pos       = (byte_pos + 1) % 3;
    end
    done_nxt = 1'b0;
    if (uart_cnt != 0) begin
      uart_cnt--;
      if (uart_cnt == 0) begin
        check("tx_data_hold", 32'(bus_if.tx_data), 32'(last_byte));
        done_nxt = 1'b1;
      end
    end
    if (bus_if.tx_start === 1'b1) begin
      uart_cnt = 10;
      if (spur_start) done_nxt = 1'b1;
    end
    if (spur_idle) done_nxt = 1'b1;
    bus_if.tx_done = done_nxt;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n;
    n = 0;
    while (!(bus_if.busy === 1'b0 && exp_byte_q.size() == 0 && exp_ack_q.size() == 0) && n < budget) begin
      step();
      n++;
    end
    check({tag, "_bytes_left"}, 32'(exp_byte_q.size()), 32'd0);
    check({tag, "_busy"}, 32'(bus_if.busy), 32'd0);
  endtask

  initial begin
    int n0;
    int n;
    checks = 0; errors = 0; cyc = 0; uart_cnt = 0; n_starts = 0;
    last_start_cyc = 0; byte_pos = 0; spur_idle = 0; spur_start = 0; last_byte = '0;
    bus_if.resp_valid = '0;
    bus_if.resp_code  = '0;
    bus_if.resp_data  = '0;
    bus_if.tx_done    = 1'b0;
    rst_n = 1'b0;

    // Reset state
    repeat (3) step();
    check("rst_ack", 32'(bus_if.resp_ack), 32'h0);
    check("rst_tx_start", 32'(bus_if.tx_start), 32'h0);
    check("rst_tx_data", 32'(bus_if.tx_data), 32'h0);
    check("rst_busy", 32'(bus_if.busy), 32'h0);
    rst_n = 1'b1;
    repeat (2) step();

    // Contention: all sensors pending, served 0..7 in order
    for (int i = 0; i < 8; i++) begin
      set_sensor(i, 8'h10 + 8'(i), 8'hA0 + 8'(i));
      push_frame(i, 8'h10 + 8'(i), 8'hA0 + 8'(i));
    end
    bus_if.resp_valid = 8'hFF;
    wait_idle("contention", 600);
    check("contention_valid_left", 32'(bus_if.resp_valid), 32'h0);

    // Single request with latency checks, then data change after capture
    set_sensor(2, 8'h01, 8'h1A);
    push_frame(2, 8'h01, 8'h1A);
    bus_if.resp_valid = 8'h04;
    step();
    check("ack_latency", 32'(bus_if.resp_ack), 32'h04);
    set_sensor(2, 8'hFF, 8'hEE);
    bus_if.resp_valid[2] = 1'b1;
    push_frame(2, 8'hFF, 8'hEE);
    step();
    check("start_latency", 32'(bus_if.tx_start), 32'h1);
    check("ack_one_cycle", 32'(bus_if.resp_ack), 32'h0);
    wait_idle("single", 200);

    // Fairness: serve 5, then 0 and 5 pending -> 0 first
    set_sensor(5, 8'h55, 8'h5A);
    push_frame(5, 8'h55, 8'h5A);
    bus_if.resp_valid = 8'h20;
    wait_idle("serve5", 200);
    set_sensor(0, 8'h0C, 8'h0D);
    set_sensor(5, 8'h56, 8'h5B);
    push_frame(0, 8'h0C, 8'h0D);
    push_frame(5, 8'h56, 8'h5B);
    bus_if.resp_valid = 8'h21;
    wait_idle("fairness", 200);

    // Spurious tx_done in IDLE and coincident with every tx_start
    spur_idle = 1'b1;
    step();
    spur_idle = 1'b0;
    step();
    check("idle_spur_busy", 32'(bus_if.busy), 32'h0);
    check("idle_spur_start", 32'(bus_if.tx_start), 32'h0);
    spur_start = 1'b1;
    set_sensor(3, 8'h33, 8'h3C);
    push_frame(3, 8'h33, 8'h3C);
    bus_if.resp_valid = 8'h08;
    wait_idle("spurious", 200);
    spur_start = 1'b0;

    // Reset after the second byte of a frame
    set_sensor(6, 8'h66, 8'h6D);
    push_frame(6, 8'h66, 8'h6D);
    bus_if.resp_valid = 8'h40;
    n0 = int'(n_starts);
    n = 0;
    while (int'(n_starts) < n0 + 2 && n < 100) begin
      step();
      n++;
    end
    check("midframe_starts", 32'(n_starts), 32'(n0 + 2));
    rst_n = 1'b0;
    #1;
    check("midrst_ack", 32'(bus_if.resp_ack), 32'h0);
    check("midrst_tx_start", 32'(bus_if.tx_start), 32'h0);
    check("midrst_busy", 32'(bus_if.busy), 32'h0);
    check("midrst_tx_data", 32'(bus_if.tx_data), 32'h0);
    check("midrst_ack_taken", 32'(exp_ack_q.size()), 32'd0);
    exp_byte_q.delete();
    uart_cnt = 0;
    byte_pos = 0;
    bus_if.tx_done = 1'b0;
    repeat (3) step();
    rst_n = 1'b1;
    step();
    set_sensor(7, 8'h77, 8'h7E);
    push_frame(7, 8'h77, 8'h7E);
    bus_if.resp_valid = 8'h80;
    step();
    step();
    check("post_rst_start", 32'(bus_if.tx_start), 32'h1);
    check("post_rst_addr", 32'(bus_if.tx_data), 32'h07);
    wait_idle("post_rst", 200);

    repeat (20) step();
    check("final_ack_q", 32'(exp_ack_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
